// File: rtl/inst_mem_if.sv
// Fetch and program-load port bundle for inst_mem.
// The master drives fetch/load requests; the slave is the memory itself.
interface inst_mem_if #(
   parameter int DEPTH_LOG2 = 10,
   parameter int XLEN       = 32
);
   logic                  inst_ce;
   logic [XLEN-1:0]       inst_addr;
   logic [XLEN-1:0]       inst;
   logic                  load_start;
   logic                  load_valid;
   logic [7:0]            load_byte;
   logic                  load_last;
   logic                  load_ready;
   logic                  load_done;
   logic                  load_err;
   logic [DEPTH_LOG2:0]   load_words;
   logic                  busy;

   modport master (
      output inst_ce, inst_addr, load_start, load_valid, load_byte, load_last,
      input  inst, load_ready, load_done, load_err, load_words, busy
   );

   modport slave (
      input  inst_ce, inst_addr, load_start, load_valid, load_byte, load_last,
      output inst, load_ready, load_done, load_err, load_words, busy
   );
endinterface

// File: rtl/inst_mem.sv
// Instruction memory with a combinational fetch port and a byte-serial program loader.
// Fetches return NOP while the loader is active or the address is misaligned/out of range.
module inst_mem #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic       clk,
   input  logic       rst,
   inst_mem_if.slave  bus
);
   // state | meaning
   // IDLE  | fetch port live, waiting for load_start
   // LOAD  | accepting bytes, assembling and writing words
   // DONE  | single-cycle completion pulse, load_start ignored
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   localparam int XLEN = 32;

   state_t                  state, state_nx;
   logic [1:0]              byte_cnt;
   logic [23:0]             buffer;
   logic [DEPTH_LOG2:0]     words;
   logic                    err;
   logic [31:0]             mem [2**DEPTH_LOG2];

   logic                    clear, accept, full, wr_en;
   logic                    ready, done, busy;
   logic [31:0]             wr_word;
   logic [DEPTH_LOG2-1:0]   waddr;
   logic [DEPTH_LOG2-1:0]   raddr;
   logic                    addr_ok;

   assign clear  = bus.load_start && (state != DONE);
   assign accept = bus.load_valid && ready && !bus.load_start;
   assign full   = words[DEPTH_LOG2];
   // Word address always tracks the count of words written in this load.
   assign waddr  = words[DEPTH_LOG2-1:0];
   assign wr_en  = accept && !full && ((byte_cnt == 2'd3) || bus.load_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.load_start) state_nx = LOAD;
         LOAD:    if (accept && bus.load_last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == LOAD);
      done  = (state == DONE);
      busy  = (state != IDLE);
   end

   // Bytes above the current position are zeroed so a short final word is clean.
   always_comb begin
      wr_word = '0;
      case (byte_cnt)
         2'd0:    wr_word = {24'h0, bus.load_byte};
         2'd1:    wr_word = {16'h0, bus.load_byte, buffer[7:0]};
         2'd2:    wr_word = {8'h0, bus.load_byte, buffer[15:0]};
         default: wr_word = {bus.load_byte, buffer};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         buffer   <= '0;
         words    <= '0;
         err      <= 1'b0;
      end else if (clear) begin
         byte_cnt <= '0;
         buffer   <= '0;
         words    <= '0;
         err      <= 1'b0;
      end else if (accept) begin
         byte_cnt <= byte_cnt + 2'd1;
         if (full) begin
            err <= 1'b1;
         end else begin
            case (byte_cnt)
               2'd0:    buffer[7:0]   <= bus.load_byte;
               2'd1:    buffer[15:8]  <= bus.load_byte;
               2'd2:    buffer[23:16] <= bus.load_byte;
               default: buffer        <= buffer;
            endcase
            if ((byte_cnt == 2'd3) || bus.load_last)
               words <= words + (DEPTH_LOG2+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[waddr] <= wr_word;
   end

   assign raddr   = bus.inst_addr[DEPTH_LOG2+1:2];
   assign addr_ok = (bus.inst_addr[1:0] == 2'b00) &&
                    (bus.inst_addr[XLEN-1:DEPTH_LOG2+2] == '0);

   assign bus.inst       = (rst || !bus.inst_ce || busy || !addr_ok) ? NOP_INST : mem[raddr];
   assign bus.load_ready = ready;
   assign bus.load_done  = done;
   assign bus.load_err   = err;
   assign bus.load_words = words;
   assign bus.busy       = busy;
endmodule

// File: tb/tb_inst_mem.sv
// Scoreboard bench for inst_mem: a 1024-word and a 4-word instance share one load stream.
// Stimulus queues expectations; negedge monitors pop them on probe strobes and done pulses.
module tb_inst_mem;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int K_INST = 0, K_BUSY = 1, K_READY = 2, K_WORDS = 3, K_ERR = 4, K_DONE = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce, ld_start, ld_valid, ld_last, strobe;
   logic [31:0] addr;
   logic [7:0]  ld_byte;

   always #5 clk = ~clk;

   inst_mem_if #(.DEPTH_LOG2(10)) f0 ();
   inst_mem_if #(.DEPTH_LOG2(2))  f1 ();

   assign f0.inst_ce = ce;       assign f1.inst_ce = ce;
   assign f0.inst_addr = addr;   assign f1.inst_addr = addr;
   assign f0.load_start = ld_start; assign f1.load_start = ld_start;
   assign f0.load_valid = ld_valid; assign f1.load_valid = ld_valid;
   assign f0.load_byte = ld_byte;   assign f1.load_byte = ld_byte;
   assign f0.load_last = ld_last;   assign f1.load_last = ld_last;

   inst_mem #(.DEPTH_LOG2(10)) u0 (.clk(clk), .rst(rst), .bus(f0));
   inst_mem #(.DEPTH_LOG2(2))  u1 (.clk(clk), .rst(rst), .bus(f1));

   typedef struct {int dut; int kind; logic [31:0] exp; string name;} probe_t;
   typedef struct {logic [31:0] words; logic err;} done_t;
   probe_t pq[$];
   done_t  dq0[$], dq1[$];
   int compared = 0, mismatched = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pick(int dut, int kind);
      logic [31:0] v;
      v = '0;
      if (dut == 0) begin
         case (kind)
            K_INST:  v = f0.inst;
            K_BUSY:  v = 32'(f0.busy);
            K_READY: v = 32'(f0.load_ready);
            K_WORDS: v = 32'(f0.load_words);
            K_ERR:   v = 32'(f0.load_err);
            default: v = 32'(f0.load_done);
         endcase
      end else begin
         case (kind)
            K_INST:  v = f1.inst;
            K_BUSY:  v = 32'(f1.busy);
            K_READY: v = 32'(f1.load_ready);
            K_WORDS: v = 32'(f1.load_words);
            K_ERR:   v = 32'(f1.load_err);
            default: v = 32'(f1.load_done);
         endcase
      end
      return v;
   endfunction

   always @(negedge clk) begin
      probe_t p;
      done_t  d;
      if (strobe) begin
         while (pq.size() > 0) begin
            p = pq.pop_front();
            chk(p.name, pick(p.dut, p.kind), p.exp);
         end
      end
      if (f0.load_done) begin
         if (dq0.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL done0_unexpected: got pulse expected none (t=%0t)", $time);
         end else begin
            d = dq0.pop_front();
            chk("done0_words", 32'(f0.load_words), d.words);
            chk("done0_err", 32'(f0.load_err), 32'(d.err));
         end
      end
      if (f1.load_done) begin
         if (dq1.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL done1_unexpected: got pulse expected none (t=%0t)", $time);
         end else begin
            d = dq1.pop_front();
            chk("done1_words", 32'(f1.load_words), d.words);
            chk("done1_err", 32'(f1.load_err), 32'(d.err));
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic probe(int dut, int kind, logic [31:0] exp, string name);
      pq.push_back('{dut, kind, exp, name});
   endtask

   task automatic sample();
      strobe = 1'b1; cyc(); strobe = 1'b0;
   endtask

   task automatic rd(int dut, logic c, logic [31:0] a, logic [31:0] exp, string name);
      ce = c; addr = a;
      probe(dut, K_INST, exp, name);
      sample();
      ce = 1'b1; addr = '0;
   endtask

   task automatic start();
      ld_start = 1'b1; cyc(); ld_start = 1'b0;
   endtask

   task automatic send(logic [7:0] b, logic last);
      ld_valid = 1'b1; ld_byte = b; ld_last = last;
      cyc();
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic expect_done(logic [31:0] w0, logic e0, logic [31:0] w1, logic e1);
      dq0.push_back('{w0, e0});
      dq1.push_back('{w1, e1});
   endtask

   initial begin
      ce = 1'b1; addr = '0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
      ld_byte = '0; strobe = 1'b0;

      // reset state
      cyc(); cyc();
      probe(0, K_INST, NOP, "rst_inst");
      probe(0, K_BUSY, 0, "rst_busy");
      probe(0, K_READY, 0, "rst_ready");
      probe(0, K_WORDS, 0, "rst_words");
      probe(1, K_INST, NOP, "rst_inst1");
      sample();
      rst = 1'b0;
      cyc();
      probe(0, K_BUSY, 0, "post_rst_busy");
      probe(0, K_DONE, 0, "post_rst_done");
      probe(0, K_ERR, 0, "post_rst_err");
      sample();

      // full word
      expect_done(1, 0, 1, 0);
      start();
      probe(0, K_READY, 1, "load_ready");
      probe(0, K_BUSY, 1, "load_busy");
      sample();
      rd(0, 1, 32'h0, NOP, "nop_during_load");
      send(8'h13, 0); send(8'h05, 0); send(8'h50, 0); send(8'h00, 1);
      probe(0, K_DONE, 1, "done_latency");
      probe(0, K_WORDS, 1, "full_words");
      probe(1, K_DONE, 1, "done_latency1");
      sample();
      rd(0, 1, 32'h0, 32'h0050_0513, "full_word");
      rd(1, 1, 32'h0, 32'h0050_0513, "full_word1");

      // address guards
      rd(0, 1, 32'h2, NOP, "misaligned");
      rd(0, 1, 32'h1000, NOP, "out_of_range");
      rd(0, 0, 32'h0, NOP, "ce_low");

      // partial word; start while DONE must be ignored
      expect_done(1, 0, 1, 0);
      start();
      send(8'hAA, 0); send(8'hBB, 1);
      ld_start = 1'b1;
      probe(0, K_DONE, 1, "partial_done");
      sample();
      ld_start = 1'b0;
      probe(0, K_BUSY, 0, "start_in_done_ignored");
      probe(0, K_WORDS, 1, "partial_words");
      sample();
      rd(0, 1, 32'h0, 32'h0000_BBAA, "partial_word");

      // restart mid-load; byte in the restart cycle is dropped
      expect_done(1, 0, 1, 0);
      start();
      send(8'h55, 0); send(8'h66, 0);
      ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h77;
      cyc();
      ld_start = 1'b0; ld_valid = 1'b0;
      probe(0, K_WORDS, 0, "restart_words_clear");
      sample();
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
      cyc();
      rd(0, 1, 32'h0, 32'h4433_2211, "restart_word");
      probe(0, K_WORDS, 1, "restart_words");
      sample();

      // overflow on the 4-word instance; 5 words land in the large one
      expect_done(5, 0, 4, 1);
      start();
      for (int i = 1; i <= 20; i++) send(8'(i), i == 20);
      probe(1, K_DONE, 1, "ovf_done");
      probe(1, K_ERR, 1, "ovf_err");
      probe(1, K_WORDS, 4, "ovf_words");
      sample();
      probe(1, K_ERR, 1, "ovf_err_sticky");
      sample();
      rd(1, 1, 32'h0, 32'h0403_0201, "ovf_w0");
      rd(1, 1, 32'hC, 32'h100F_0E0D, "ovf_w3");
      rd(1, 1, 32'h10, NOP, "ovf_range1");
      rd(0, 1, 32'h10, 32'h1413_1211, "big_w4");

      // reset mid-load: completed words stay, partial word lost
      start();
      probe(1, K_ERR, 0, "err_cleared_by_start");
      sample();
      for (int i = 0; i < 6; i++) send(8'hA1 + 8'(i), 0);
      rst = 1'b1;
      probe(0, K_BUSY, 0, "midrst_busy");
      probe(0, K_WORDS, 0, "midrst_words");
      probe(0, K_INST, NOP, "midrst_inst");
      sample();
      rst = 1'b0;
      cyc();
      rd(0, 1, 32'h0, 32'hA4A3_A2A1, "midrst_w0");
      rd(0, 1, 32'h4, 32'h0807_0605, "midrst_w1_kept");
      rd(1, 1, 32'h4, 32'h0807_0605, "midrst_w1_kept1");

      cyc(); cyc(); cyc();
      chk("done0_outstanding", 32'(dq0.size()), 0);
      chk("done1_outstanding", 32'(dq1.size()), 0);
      chk("probe_outstanding", 32'(pq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
